proc_io_bridge: RTL and testbench
=================================

Name: proc_io_bridge

Overview:
- Peripheral-side responder for the processor I/O port bus. The processor side is `io_in`/`io_out` plus one-hot `req_in`/`out_en` from the address decoders.
- Each processor input port is backed by a first-word-fall-through (FWFT) FIFO, filled from an external valid/ready stream.
- Each processor output port is backed by a FIFO, drained to an external valid/ready stream.
- Sits between a `proc_fx`-based core wrapper and the system streams, and decouples processor I/O instructions from external producer and consumer timing.

Parameters:
- NUBITS, 32: data word width.
- NUIOIN, 2: number of processor input ports (width of `req_in`).
- NUIOOU, 2: number of processor output ports (width of `out_en`).
- FDEPTH, 8: entries per FIFO; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- req_in  in  NUIOIN  one-hot processor read strobe, one bit per input port.
- io_in  out  NUBITS  data returned to the processor.
- out_en  in  NUIOOU  one-hot processor write strobe, one bit per output port.
- io_out  in  NUBITS  data written by the processor.
- s_data  in  NUIOIN*NUBITS  external input words; port k occupies bits [k*NUBITS +: NUBITS].
- s_valid  in  NUIOIN  external input valid.
- s_ready  out  NUIOIN  input FIFO k not full.
- m_data  out  NUIOOU*NUBITS  output FIFO heads, packed the same way as s_data.
- m_valid  out  NUIOOU  output FIFO k not empty.
- m_ready  in  NUIOOU  external consumer ready.
- underflow  out  NUIOIN  sticky flag: read of an empty input port.
- overflow  out  NUIOOU  sticky flag: write to a full output port.

Behaviour:
- Reset (rst=0, asynchronous):
  - All FIFO pointers and counts go to 0.
  - s_ready becomes all-ones; m_valid, underflow and overflow become all-zeros.
  - io_in and m_data read 0.
  - Reset mid-transfer discards all FIFO contents; there is no partial-word state.
- FIFO element behaviour:
  - Push on valid&&ready. Pop on a consumer strobe.
  - A push and a pop in the same cycle both take effect; count is unchanged.
  - ready = (count != FDEPTH), computed from registered count only. A full FIFO does not accept a push even when it is popped in the same cycle.
  - Pointers wrap modulo FDEPTH.
  - Count width is clog2(FDEPTH)+1.
- Processor read path:
  - io_in is combinational, zero-latency: the head of input FIFO k, where k is the lowest set bit of req_in.
  - FIFO k pops on the clk edge that ends the strobe cycle.
  - req_in all-zero: io_in = 0, no pop.
  - More than one bit set: only the lowest-index port is served and popped; the other ports are untouched.
  - Read of an empty port k: io_in = 0, no pointer change, underflow[k] set.
- Processor write path:
  - On out_en[k], io_out is pushed into output FIFO k at the clk edge. The lowest set bit wins if more than one is set.
  - Write to a full FIFO: the word is dropped and overflow[k] is set.
- External drain:
  - m_data slice k = FIFO k head, valid whenever non-empty.
  - m_valid&&m_ready pops the FIFO.
  - A processor write and an external pop in the same cycle are both honoured.
- Sticky flags clear only on reset.
- Throughput: one word per port per cycle in each direction.
- No state machine beyond FIFO occupancy.

Decomposition:
- Shared package/include holds:
  - a clog2 function;
  - a lowest-set-bit encoder function, reused for req_in and out_en.
- One sub-module, `io_fifo`, parameterised on NUBITS and FDEPTH, with push/pop, FWFT head, full/empty and async active-low reset.
- The top instantiates NUIOIN + NUIOOU copies in generate loops, plus the strobe encoders and the io_in mux.

Test Plan:
- Reset then idle:
  - io_in=0, s_ready=2'b11, m_valid=0, flags=0.
  - Assert rst low mid-burst with 3 words queued → m_valid drops immediately (asynchronously) and the queued words are never delivered after release.
- Input path:
  - Push 0x11,0x22,0x33 on port 1 via s_valid.
  - Strobe req_in=2'b10 for 3 cycles → io_in reads 0x11,0x22,0x33 in those cycles.
  - A 4th strobe → io_in=0 and underflow=2'b10.
- Output path:
  - out_en=2'b01 with io_out=0xDEADBEEF and m_ready=0 → m_valid[0]=1 and m_data[31:0]=0xDEADBEEF the next cycle.
  - FDEPTH+1 writes → overflow[0]=1 and the FIFO holds the first 8 words.
- Full input FIFO:
  - Fill port 0 with 8 words → s_ready[0]=0.
  - Same-cycle req_in=2'b01 and s_valid[0]=1 → a pop occurs, no push; s_ready[0]=1 the next cycle.
- Concurrency:
  - Steady out_en[1] every cycle with m_ready[1]=1 → count stays 1 and there is no overflow.
  - req_in=2'b11 → only port 0 pops and port 1 is unchanged.
- Wrap-around:
  - Stream 20 sequential words through port 0 with random s_valid/req_in gaps → strict in-order delivery and no flags set.

Source files
------------

// File: rtl/proc_io_bridge_pkg.sv
// Purpose : shared helpers for the processor I/O bridge (clog2, lowest-set-bit encoder).
// Latency : n/a (compile-time and combinational functions only).
// Backpressure: n/a.
// Contents: clog2() for pointer sizing, lsb_index() for one-hot strobe priority.
package proc_io_bridge_pkg;

  // Widest strobe vector the encoder accepts; strobe widths above this are not supported.
  localparam int ENC_W = 32;
  localparam int LSB_W = 5;

  function automatic int clog2(input int value);
    int v;
    clog2 = 0;
    v = value - 1;
    while (v > 0) begin
      clog2 = clog2 + 1;
      v = v >> 1;
    end
  endfunction

  // Index of the lowest set bit; returns 0 for an all-zero vector, so callers
  // must qualify the result with a separate "any bit set" term.
  function automatic logic [LSB_W-1:0] lsb_index(input logic [ENC_W-1:0] vec);
    lsb_index = '0;
    for (int i = ENC_W - 1; i >= 0; i--) begin
      if (vec[i]) lsb_index = LSB_W'(i);
    end
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Purpose : single-clock first-word-fall-through FIFO backing one processor I/O port.
// Latency : a pushed word is visible on head the cycle after the push edge; pop is zero-latency.
// Backpressure: full is registered-count only; a push while full is ignored even if popped that cycle.
// Ports   : clk, rst (async active-low), push/push_data, pop, head (0 when empty), full, empty.
module io_fifo
  import proc_io_bridge_pkg::*;
#(
  parameter int NUBITS = 32,
  parameter int FDEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [NUBITS-1:0] push_data,
  input  logic              pop,
  output logic [NUBITS-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PTRW = clog2(FDEPTH);
  localparam int CNTW = PTRW + 1;

  logic [NUBITS-1:0] mem [FDEPTH];
  logic [PTRW-1:0]   wr_ptr;
  logic [PTRW-1:0]   rd_ptr;
  logic [CNTW-1:0]   count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNTW'(FDEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is forced to zero when empty so the processor sees 0 on an underflow read.
  assign head = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset: contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // FDEPTH is a power of two, so pointer wrap is the natural PTRW-bit rollover.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/proc_io_bridge.sv
// Purpose : peripheral responder for the processor I/O port bus; FIFOs decouple I/O
//           instructions from external valid/ready producers and consumers.
// Latency : io_in is combinational from the input FIFO head; processor writes reach m_data next cycle.
// Backpressure: s_ready drops when an input FIFO is full; writes to a full output FIFO are dropped
//           and flagged in overflow; reads of an empty input port return 0 and flag underflow.
// Ports   : req_in/io_in (processor read), out_en/io_out (processor write),
//           s_* (input streams), m_* (output streams), underflow/overflow (sticky).
module proc_io_bridge
  import proc_io_bridge_pkg::*;
#(
  parameter int NUBITS = 32,
  parameter int NUIOIN = 2,
  parameter int NUIOOU = 2,
  parameter int FDEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUIOIN-1:0]        req_in,
  output logic [NUBITS-1:0]        io_in,
  input  logic [NUIOOU-1:0]        out_en,
  input  logic [NUBITS-1:0]        io_out,
  input  logic [NUIOIN*NUBITS-1:0] s_data,
  input  logic [NUIOIN-1:0]        s_valid,
  output logic [NUIOIN-1:0]        s_ready,
  output logic [NUIOOU*NUBITS-1:0] m_data,
  output logic [NUIOOU-1:0]        m_valid,
  input  logic [NUIOOU-1:0]        m_ready,
  output logic [NUIOIN-1:0]        underflow,
  output logic [NUIOOU-1:0]        overflow
);

  // ---------------- strobe priority encoders ----------------
  logic             rd_any;
  logic             wr_any;
  logic [LSB_W-1:0] rd_idx;
  logic [LSB_W-1:0] wr_idx;

  assign rd_any = |req_in;
  assign wr_any = |out_en;
  assign rd_idx = lsb_index(ENC_W'(req_in));
  assign wr_idx = lsb_index(ENC_W'(out_en));

  // ---------------- processor input ports ----------------
  logic [NUIOIN-1:0] rd_sel;
  logic [NUIOIN-1:0] in_full;
  logic [NUIOIN-1:0] in_empty;
  logic [NUBITS-1:0] in_head [NUIOIN];

  for (genvar k = 0; k < NUIOIN; k++) begin : g_in
    assign rd_sel[k]  = rd_any && (rd_idx == LSB_W'(k));
    assign s_ready[k] = ~in_full[k];

    io_fifo #(
      .NUBITS (NUBITS),
      .FDEPTH (FDEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (s_valid[k]),
      .push_data (s_data[k*NUBITS +: NUBITS]),
      .pop       (rd_sel[k]),
      .head      (in_head[k]),
      .full      (in_full[k]),
      .empty     (in_empty[k])
    );
  end

  // rd_sel is one-hot or zero, so a plain priority-free select is sufficient.
  always_comb begin
    io_in = '0;
    for (int k = 0; k < NUIOIN; k++) begin
      if (rd_sel[k]) io_in = in_head[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) underflow <= '0;
    else      underflow <= underflow | (rd_sel & in_empty);
  end

  // ---------------- processor output ports ----------------
  logic [NUIOOU-1:0] wr_sel;
  logic [NUIOOU-1:0] out_full;
  logic [NUIOOU-1:0] out_empty;

  for (genvar k = 0; k < NUIOOU; k++) begin : g_out
    assign wr_sel[k]  = wr_any && (wr_idx == LSB_W'(k));
    assign m_valid[k] = ~out_empty[k];

    io_fifo #(
      .NUBITS (NUBITS),
      .FDEPTH (FDEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (wr_sel[k]),
      .push_data (io_out),
      .pop       (m_ready[k]),
      .head      (m_data[k*NUBITS +: NUBITS]),
      .full      (out_full[k]),
      .empty     (out_empty[k])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow <= '0;
    else      overflow <= overflow | (wr_sel & out_full);
  end

endmodule

// File: tb/tb_proc_io_bridge.sv
// Purpose : self-checking bench for proc_io_bridge using per-port scoreboard queues.
// Latency : inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: s_ready/m_valid compared against a queue-occupancy model.
module tb_proc_io_bridge;

  localparam int NB = 32;
  localparam int NI = 2;
  localparam int NO = 2;
  localparam int FD = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NI-1:0]    req_in = '0;
  logic [NB-1:0]    io_in;
  logic [NO-1:0]    out_en = '0;
  logic [NB-1:0]    io_out = '0;
  logic [NI*NB-1:0] s_data = '0;
  logic [NI-1:0]    s_valid = '0;
  logic [NI-1:0]    s_ready;
  logic [NO*NB-1:0] m_data;
  logic [NO-1:0]    m_valid;
  logic [NO-1:0]    m_ready = '0;
  logic [NI-1:0]    underflow;
  logic [NO-1:0]    overflow;

  proc_io_bridge #(.NUBITS(NB), .NUIOIN(NI), .NUIOOU(NO), .FDEPTH(FD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .io_in     (io_in),
    .out_en    (out_en),
    .io_out    (io_out),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .underflow (underflow),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] in_q [$];
  logic [31:0] out_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Commit one rising edge and return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int sent;
    int got;
    int cyc;
    logic do_req;
    logic do_push;
    logic accept;
    logic [31:0] w;

    // ---------------- reset state ----------------
    #2 rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_io_in",     64'(io_in),     64'h0);
    check("rst_s_ready",   64'(s_ready),   64'h3);
    check("rst_m_valid",   64'(m_valid),   64'h0);
    check("rst_underflow", 64'(underflow), 64'h0);
    check("rst_overflow",  64'(overflow),  64'h0);
    rst = 1'b1;
    tick();

    // ---------------- wrap-around stream on input port 0 ----------------
    sent = 0; got = 0; cyc = 0;
    in_q.delete();
    while (got < 20 && cyc < 500) begin
      do_req  = (in_q.size() > 0) && ($urandom_range(0, 2) != 0);
      do_push = (sent < 20) && ($urandom_range(0, 2) != 0);
      req_in  = {1'b0, do_req};
      s_valid = {1'b0, do_push};
      s_data[31:0] = 32'h100 + 32'(sent);
      #1;
      check("wrap_s_ready", 64'(s_ready[0]), 64'(in_q.size() < FD));
      if (do_req) check("wrap_io_in", 64'(io_in), 64'(in_q[0]));
      accept = do_push && (in_q.size() < FD);
      tick();
      if (do_req) begin
        void'(in_q.pop_front());
        got++;
      end
      if (accept) begin
        in_q.push_back(32'h100 + 32'(sent));
        sent++;
      end
      cyc++;
    end
    req_in = '0; s_valid = '0;
    check("wrap_done", 64'(got), 64'd20);
    #1;
    check("wrap_underflow", 64'(underflow), 64'h0);
    check("wrap_overflow",  64'(overflow),  64'h0);
    tick();

    // ---------------- input path, port 1 ----------------
    in_q.delete();
    for (int i = 0; i < 3; i++) begin
      w = 32'h11 * 32'(i + 1);
      s_valid = 2'b10;
      s_data[63:32] = w;
      in_q.push_back(w);
      tick();
    end
    s_valid = '0;
    for (int i = 0; i < 3; i++) begin
      req_in = 2'b10;
      #1;
      check("rd_port1", 64'(io_in), 64'(in_q[0]));
      tick();
      void'(in_q.pop_front());
    end
    req_in = 2'b10;
    #1;
    check("rd_empty_io_in", 64'(io_in), 64'h0);
    tick();
    req_in = '0;
    #1;
    check("rd_underflow", 64'(underflow), 64'h2);

    // ---------------- output path, port 0, overflow ----------------
    out_q.delete();
    m_ready = '0;
    for (int i = 0; i < FD + 1; i++) begin
      w = (i == 0) ? 32'hDEADBEEF : 32'h300 + 32'(i);
      out_en = 2'b01;
      io_out = w;
      if (out_q.size() < FD) out_q.push_back(w);
      tick();
      if (i == 0) begin
        #1;
        check("wr_m_valid0", 64'(m_valid[0]),  64'h1);
        check("wr_m_data0",  64'(m_data[31:0]), 64'hDEADBEEF);
      end
    end
    out_en = '0;
    #1;
    check("wr_overflow", 64'(overflow), 64'h1);
    m_ready = 2'b01;
    for (int i = 0; i < FD; i++) begin
      #1;
      check("drain_m_valid0", 64'(m_valid[0]),  64'h1);
      check("drain_m_data0",  64'(m_data[31:0]), 64'(out_q[0]));
      tick();
      void'(out_q.pop_front());
    end
    m_ready = '0;
    #1;
    check("drain_empty", 64'(m_valid[0]), 64'h0);

    // ---------------- full input FIFO, simultaneous pop and push attempt ----------------
    in_q.delete();
    for (int i = 0; i < FD; i++) begin
      s_valid = 2'b01;
      s_data[31:0] = 32'h200 + 32'(i);
      in_q.push_back(32'h200 + 32'(i));
      tick();
    end
    s_valid = '0;
    #1;
    check("full_s_ready", 64'(s_ready[0]), 64'h0);
    tick();
    req_in = 2'b01; s_valid = 2'b01; s_data[31:0] = 32'h0BAD;
    #1;
    check("full_pop_io_in", 64'(io_in), 64'(in_q[0]));
    tick();
    void'(in_q.pop_front());
    req_in = '0; s_valid = '0;
    #1;
    check("full_ready_after", 64'(s_ready[0]), 64'h1);
    while (in_q.size() > 0) begin
      req_in = 2'b01;
      #1;
      check("full_drain", 64'(io_in), 64'(in_q[0]));
      tick();
      void'(in_q.pop_front());
    end
    req_in = '0;
    #1;
    check("full_underflow0", 64'(underflow[0]), 64'h0);

    // ---------------- concurrent write and drain on output port 1 ----------------
    out_q.delete();
    m_ready = 2'b10;
    for (int i = 0; i < 10; i++) begin
      out_en = 2'b10;
      io_out = 32'h500 + 32'(i);
      #1;
      if (i > 0) begin
        check("conc_m_valid1", 64'(m_valid[1]),   64'h1);
        check("conc_m_data1",  64'(m_data[63:32]), 64'(out_q[0]));
      end
      tick();
      if (i > 0) void'(out_q.pop_front());
      out_q.push_back(32'h500 + 32'(i));
    end
    out_en = '0;
    #1;
    check("conc_last", 64'(m_data[63:32]), 64'(out_q[0]));
    tick();
    void'(out_q.pop_front());
    m_ready = '0;
    #1;
    check("conc_empty",     64'(m_valid[1]),  64'h0);
    check("conc_overflow1", 64'(overflow[1]), 64'h0);

    // ---------------- multi-bit read strobe ----------------
    s_valid = 2'b11;
    s_data = {32'hB0B0_0001, 32'hA0A0_0000};
    tick();
    s_valid = '0;
    req_in = 2'b11;
    #1;
    check("multi_io_in", 64'(io_in), 64'hA0A0_0000);
    tick();
    req_in = 2'b10;
    #1;
    check("multi_port1_kept", 64'(io_in), 64'hB0B0_0001);
    tick();
    req_in = '0;
    #1;
    check("multi_underflow0", 64'(underflow[0]), 64'h0);

    // ---------------- asynchronous reset mid-burst ----------------
    m_ready = '0;
    for (int i = 0; i < 3; i++) begin
      out_en = 2'b01;
      io_out = 32'h700 + 32'(i);
      tick();
    end
    out_en = '0;
    #1;
    check("burst_m_valid", 64'(m_valid[0]), 64'h1);
    #2 rst = 1'b0;
    #1;
    check("arst_m_valid",   64'(m_valid),   64'h0);
    check("arst_s_ready",   64'(s_ready),   64'h3);
    check("arst_overflow",  64'(overflow),  64'h0);
    check("arst_underflow", 64'(underflow), 64'h0);
    check("arst_m_data",    64'(m_data),    64'h0);
    tick();
    rst = 1'b1;
    m_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      check("post_rst_m_valid", 64'(m_valid), 64'h0);
    end
    m_ready = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
